aes_decrypt_iter: RTL and testbench
===================================

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data and key are valid.
- in_ready  out  1  block can accept a new block.
- data  in  128  ciphertext block.
- key  in  128  final (round-10) AES-128 round key.
- out  out  128  plaintext block.
- out_valid  out  1  out is valid.
- out_ready  in  1  consumer accepts out.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 Byte 0 SHALL be bits [127:120], and the state SHALL be column-major (bytes 0-3 form column 0), identical to the encrypt round.
REQ-004 The block SHALL have no parameters.

Function
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; a transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-007 On a transfer, the block SHALL load state <= data XOR key, kreg <= key and rnd <= 10, and SHALL move to RUN.
REQ-008 Each RUN cycle SHALL perform both of the following:
- nk = inverse key expansion of kreg using Rcon(rnd).
- state <= InvShiftRows, then InvSubBytes, then XOR nk, then InvMixColumns, with InvMixColumns omitted when rnd=1.
REQ-009 Each RUN cycle SHALL also load kreg <= nk and rnd <= rnd-1.
REQ-010 Inverse key expansion SHALL use words w4..w7 of kreg and produce w0..w3 as follows:
- w3 = w7^w6, w2 = w6^w5, w1 = w5^w4.
- w0 = w4 ^ SubWord(RotWord(w3)) ^ {Rcon(rnd),00,00,00}.
REQ-011 Rcon for rnd=1..10 SHALL be 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
REQ-012 When a RUN cycle executes with rnd=1, the FSM SHALL move to DONE; RUN SHALL last exactly 10 cycles.
REQ-013 out_valid SHALL equal 1 in DONE, asserted 10 cycles after the accepting edge.
REQ-014 out SHALL equal state while in DONE, and SHALL hold stable until the edge on which out_ready=1.
REQ-015 DONE with out_ready=1 SHALL return the FSM to IDLE; in_ready SHALL stay 0 during that cycle, so no same-cycle accept is possible.
REQ-016 in_valid SHALL be ignored in RUN and DONE.
REQ-017 out_ready SHALL be ignored outside DONE.
REQ-018 A change on data or key after acceptance SHALL NOT affect the result.
REQ-019 Throughput SHALL be one block per 12 cycles minimum: accept, 10 RUN cycles, and 1 DONE cycle with out_ready held high.
REQ-020 InvSubBytes SHALL use the FIPS-197 inverse S-box.
REQ-021 Key expansion SHALL use the forward S-box; the team's existing forward substitution logic MAY be instantiated.
REQ-022 The datapath SHALL be combinational within one cycle, with no multicycle paths.

Reset
REQ-023 While rst=1 at a rising edge, the FSM SHALL go to IDLE, and state, kreg and out SHALL become 0.
REQ-024 While rst=1 at a rising edge, rnd SHALL become 0, out_valid SHALL become 0, and in_ready SHALL become 1 on the following cycle.
REQ-025 Reset asserted during RUN or DONE SHALL abort the block with no output.
REQ-026 rst SHALL take priority over in_valid on the same edge.

Verification
REQ-027 FIPS-197 App. B: data=3925841d02dc09fbdc118597196a0b32, key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> out=3243f6a8885a308d313198a2e0370734, with out_valid exactly 10 cycles after accept.
REQ-028 FIPS-197 C.1: data=69c4e0d86a7b0430d8cdb78070b4c55a, key=13111d7fe3944a17f307a78b4d2b30c5 -> out=00112233445566778899aabbccddeeff.
REQ-029 Backpressure: run REQ-027 with out_ready held 0 for 20 cycles -> out and out_valid stay stable, in_ready=0, and a pulse on in_valid is ignored; out_ready=1 -> IDLE on the next cycle.
REQ-030 Back-to-back: queue REQ-027 then REQ-028 with in_valid held high and out_ready=1 -> two correct results, 12 cycles apart.
REQ-031 Reset mid-run: assert rst at RUN cycle 5 -> out_valid never asserts, in_ready=1 after reset, and a following REQ-028 vector passes.
REQ-032 Data change: alter data and key during RUN -> the result still matches the vector captured at accept.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 decryption, one round per clock.
// Starts from the round-10 key and walks the key schedule backwards.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

    st_t          st;
    logic [127:0] state;
    logic [127:0] kreg;
    logic [3:0]   rnd;
    logic [127:0] nk;
    logic [127:0] sb;
    logic [127:0] mix;
    logic [127:0] nxt;
    logic [31:0]  w3;
    logic [31:0]  sw;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
          ^ {a[1:0], a[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Previous round key from words w4..w7 of the current one
    assign w3 = kreg[31:0] ^ kreg[63:32];
    assign sw = {sbox(w3[23:16]), sbox(w3[15:8]),
                 sbox(w3[7:0]),   sbox(w3[31:24])};
    assign nk = {kreg[127:96] ^ sw ^ {rcon(rnd), 24'h0},
                 kreg[95:64] ^ kreg[127:96],
                 kreg[63:32] ^ kreg[95:64],
                 w3};

    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int C = i / 4;
        localparam int R = i % 4;
        localparam int S = ((C + 4 - R) % 4) * 4 + R;
        assign sb[127-8*i -: 8] =
            inv_sbox(state[127-8*S -: 8]) ^ nk[127-8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sb[127-32*c -: 8];
        assign a1 = sb[119-32*c -: 8];
        assign a2 = sb[111-32*c -: 8];
        assign a3 = sb[103-32*c -: 8];
        assign mix[127-32*c -: 32] = {
            gmul(8'h0e, a0) ^ gmul(8'h0b, a1)
          ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
            gmul(8'h09, a0) ^ gmul(8'h0e, a1)
          ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
            gmul(8'h0d, a0) ^ gmul(8'h09, a1)
          ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
            gmul(8'h0b, a0) ^ gmul(8'h0d, a1)
          ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
    end

    assign nxt = (rnd == 4'd1) ? sb : mix;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            state     <= '0;
            kreg      <= '0;
            rnd       <= 4'd0;
            out       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (st)
                IDLE: if (in_valid) begin
                    state    <= data ^ key;
                    kreg     <= key;
                    rnd      <= 4'd10;
                    in_ready <= 1'b0;
                    st       <= RUN;
                end
                RUN: begin
                    state <= nxt;
                    kreg  <= nk;
                    rnd   <= rnd - 4'd1;
                    if (rnd == 4'd1) begin
                        out       <= nxt;
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter: FIPS-197 vectors, backpressure, reset and
// random blocks against a textbook inverse-cipher model.
module tb_aes_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] out;
    logic         out_valid;
    logic         out_ready;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_C = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];
    logic [7:0] rcon_t  [11];

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .key       (key),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 0;
        while (b != 0) begin
            if (b[0]) p ^= a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_tables;
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
                     ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_t[x] = s;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
        rcon_t[0] = 0;
        rcon_t[1] = 8'h01;
        for (int j = 2; j < 11; j++) rcon_t[j] = xtime(rcon_t[j-1]);
    endtask

    function automatic logic [127:0] ref_dec(input logic [127:0] ct,
                                             input logic [127:0] k10);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tmp;
        logic [7:0]   a [4];
        logic [127:0] r;
        for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
        for (int i = 43; i >= 4; i--) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]],
                       sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp[31:24] ^= rcon_t[i/4];
            end
            w[i-4] = w[i] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
                s[q][c] = ct[127-8*(4*c+q) -: 8];
        for (int rd = 10; rd >= 0; rd--) begin
            if (rd < 10) begin
                for (int q = 0; q < 4; q++)
                    for (int c = 0; c < 4; c++)
                        t[q][c] = isbox_t[s[q][(c+4-q)%4]];
                s = t;
            end
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    s[q][c] ^= w[4*rd+c][31-8*q -: 8];
            if (rd < 10 && rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int q = 0; q < 4; q++) a[q] = s[q][c];
                    s[0][c] = gm(8'h0e,a[0])^gm(8'h0b,a[1])^gm(8'h0d,a[2])^gm(8'h09,a[3]);
                    s[1][c] = gm(8'h09,a[0])^gm(8'h0e,a[1])^gm(8'h0b,a[2])^gm(8'h0d,a[3]);
                    s[2][c] = gm(8'h0d,a[0])^gm(8'h09,a[1])^gm(8'h0e,a[2])^gm(8'h0b,a[3]);
                    s[3][c] = gm(8'h0b,a[0])^gm(8'h0d,a[1])^gm(8'h09,a[2])^gm(8'h0e,a[3]);
                end
            end
        end
        for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
                r[127-8*(4*c+q) -: 8] = s[q][c];
        return r;
    endfunction

    function automatic logic [127:0] rnd128;
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] ct, input logic [127:0] k);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        chk("ready_wait", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        data     = ct;
        key      = k;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic get(output logic [127:0] res, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick;
            lat++;
        end
        res = out;
    endtask

    logic [127:0] res;
    logic [127:0] ct;
    logic [127:0] k;
    logic [127:0] exp;
    int           lat;
    int           gap;
    int           seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = '0;
        key       = '0;
        build_tables();
        chk("model_b", ref_dec(CT_B, KEY_B), PT_B);
        chk("model_c", ref_dec(CT_C, KEY_C), PT_C);

        repeat (3) tick;
        rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out", out, 128'd0);

        out_ready = 1'b1;
        send(CT_B, KEY_B);
        chk("run_in_ready", 128'(in_ready), 128'd0);
        get(res, lat);
        chk("b_latency", 128'(lat), 128'd10);
        chk("b_out", res, PT_B);
        tick;
        chk("b_idle", 128'({out_valid, in_ready}), 128'b01);

        send(CT_C, KEY_C);
        get(res, lat);
        chk("c_latency", 128'(lat), 128'd10);
        chk("c_out", res, PT_C);
        tick;

        out_ready = 1'b0;
        send(CT_B, KEY_B);
        get(res, lat);
        chk("bp_out", res, PT_B);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 7);
            data     = CT_C;
            key      = KEY_C;
            tick;
            chk("bp_hold_out", out, PT_B);
            chk("bp_hold_flags", 128'({out_valid, in_ready}), 128'b10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("bp_release", 128'({out_valid, in_ready}), 128'b01);

        in_valid = 1'b1;
        data     = CT_B;
        key      = KEY_B;
        tick;
        data = CT_C;
        key  = KEY_C;
        get(res, lat);
        chk("b2b_first", res, PT_B);
        tick;
        chk("b2b_ready", 128'(in_ready), 128'd1);
        tick;
        in_valid = 1'b0;
        get(res, gap);
        chk("b2b_second", res, PT_C);
        chk("b2b_gap", 128'(gap + 2), 128'd12);
        tick;

        send(CT_B, KEY_B);
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_flags", 128'({out_valid, in_ready}), 128'b01);
        chk("abort_out", out, 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (out_valid) seen++;
        end
        chk("abort_no_out", 128'(seen), 128'd0);
        send(CT_C, KEY_C);
        get(res, lat);
        chk("abort_then_c", res, PT_C);
        tick;

        for (int n = 0; n < 16; n++) begin
            int hold;
            ct        = rnd128();
            k         = rnd128();
            exp       = ref_dec(ct, k);
            hold      = $urandom_range(0, 3);
            out_ready = 1'b0;
            send(ct, k);
            data = rnd128();
            key  = rnd128();
            tick;
            data = rnd128();
            get(res, lat);
            chk("rnd_latency", 128'(lat + 1), 128'd10);
            chk("rnd_out", res, exp);
            for (int h = 0; h < hold; h++) begin
                tick;
                chk("rnd_hold", out, exp);
            end
            out_ready = 1'b1;
            tick;
            chk("rnd_release", 128'({out_valid, in_ready}), 128'b01);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
